// File: rtl/facc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | facc_pkg : shared types and constants for the FP accumulator               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package facc_pkg;

    localparam int EXP_WIDTH  = 8;
    localparam int MANT_WIDTH = 23;
    localparam int SIG_WIDTH  = MANT_WIDTH + 1;
    localparam int EXP_BIAS   = 127;
    localparam int EXP_MAX    = 2 * EXP_BIAS + 1;

    localparam logic [31:0] FP_NAN     = 32'h7FC0_0000;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_OUT   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/facc_lzc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | facc_lzc : leading-zero counter; returns WIDTH for an all-zero input       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module facc_lzc
    import facc_pkg::*;
#(
    parameter int WIDTH = SIG_WIDTH + 3,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/facc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | facc : multi-cycle IEEE-754 single-precision group accumulator.            |
// |        Define FACC_ROUND_NEAREST_EN for round-to-nearest-even (else trunc). |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module facc
    import facc_pkg::*;
#(
    parameter int GUARD_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int W  = SIG_WIDTH + GUARD_BITS;
    localparam int CW = $clog2(W + 1);
    localparam int SW = $clog2(W);
    localparam int XW = EXP_WIDTH + 2;
    localparam logic [EXP_WIDTH-1:0] W_EXP = EXP_WIDTH'(W);

    state_t r_state, w_next;

    logic [31:0]   r_op, r_acc, r_spec_val;
    logic          r_last, r_nan, r_special, r_sign, r_sub;
    logic [XW-1:0] r_exp;
    logic [W-1:0]  r_big_sig, r_small_sig, r_norm;
    logic [W:0]    r_sum;

    // ---------------- state register and next-state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_ALIGN;
            S_ALIGN: w_next = S_ADD;
            S_ADD:   w_next = S_NORM;
            S_NORM:  w_next = S_ROUND;
            S_ROUND: w_next = r_last ? S_OUT : S_IDLE;
            S_OUT:   if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = out_valid ? (r_nan ? FP_NAN : r_acc) : FP_ZERO;

    // ---------------- ALIGN: classify, order by magnitude, shift ----------------
    logic [31:0]          w_op, w_big, w_small, w_spec_val;
    logic                 w_op_nan, w_op_inf, w_acc_inf, w_swap, w_special, w_nan_set;
    logic [W-1:0]         w_big_sig, w_small_sig, w_small_aligned, w_lost;
    logic [EXP_WIDTH-1:0] w_diff;

    // Zero and subnormal operands collapse to +0.
    assign w_op      = (r_op[30:23] == '0) ? FP_ZERO : r_op;
    assign w_op_nan  = (&w_op[30:23]) && (|w_op[22:0]);
    assign w_op_inf  = (w_op[30:0] == FP_POS_INF[30:0]);
    assign w_acc_inf = (r_acc[30:0] == FP_POS_INF[30:0]);
    assign w_swap    = (w_op[30:0] > r_acc[30:0]);
    assign w_big     = w_swap ? w_op : r_acc;
    assign w_small   = w_swap ? r_acc : w_op;
    assign w_diff    = w_big[30:23] - w_small[30:23];

    assign w_big_sig   = {|w_big[30:23], w_big[22:0], {GUARD_BITS{1'b0}}};
    assign w_small_sig = {|w_small[30:23], w_small[22:0], {GUARD_BITS{1'b0}}};

    assign w_nan_set  = w_op_nan || (w_acc_inf && w_op_inf && (r_acc[31] != w_op[31]));
    assign w_special  = w_op_nan || w_acc_inf || w_op_inf;
    assign w_spec_val = (w_op_nan || w_acc_inf) ? r_acc : w_op;

    always_comb begin
        w_small_aligned = '0;
        w_lost          = '0;
        if (w_diff >= W_EXP) begin
            w_small_aligned = {{(W-1){1'b0}}, |w_small_sig};
        end else begin
            w_small_aligned    = w_small_sig >> w_diff[SW-1:0];
            w_lost             = w_small_sig & ~({W{1'b1}} << w_diff[SW-1:0]);
            w_small_aligned[0] = w_small_aligned[0] | (|w_lost);
        end
    end

    // ---------------- NORM: leading-zero count ----------------
    logic [CW-1:0] w_lz;

    facc_lzc #(
        .WIDTH (W)
    ) u_lzc (
        .value (r_sum[W-1:0]),
        .count (w_lz)
    );

    // ---------------- ROUND: rounding increment and packing ----------------
    logic                 w_inc, w_zero;
    logic [SIG_WIDTH-1:0] w_rnd;
    logic [XW-1:0]        w_rexp;
    logic [31:0]          w_packed;

`ifdef FACC_ROUND_NEAREST_EN
    logic w_guard, w_rs;
    assign w_guard = r_norm[GUARD_BITS-1];
    assign w_rs    = |r_norm[GUARD_BITS-2:0];
    assign w_inc   = w_guard && (w_rs || r_norm[GUARD_BITS]);
`else
    logic w_unused_grs;
    assign w_unused_grs = ^r_norm[GUARD_BITS-1:0];
    assign w_inc        = 1'b0;
`endif

    // An all-ones fraction rounding up leaves a zero fraction and a carry.
    assign w_rnd  = {1'b0, r_norm[W-2:GUARD_BITS]} + SIG_WIDTH'(w_inc);
    assign w_rexp = r_exp + XW'(w_rnd[SIG_WIDTH-1]);
    assign w_zero = ~r_norm[W-1];

    always_comb begin
        w_packed = FP_ZERO;
        if (r_special) begin
            w_packed = r_spec_val;
        end else if (w_zero) begin
            w_packed = FP_ZERO;
        end else if (!w_rexp[XW-1] && (w_rexp >= XW'(EXP_MAX))) begin
            w_packed = {r_sign, FP_POS_INF[30:0]};
        end else if (w_rexp[XW-1] || (w_rexp == '0)) begin
            w_packed = FP_ZERO;
        end else begin
            w_packed = {r_sign, w_rexp[EXP_WIDTH-1:0], w_rnd[MANT_WIDTH-1:0]};
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= FP_ZERO;
            r_last      <= 1'b0;
            r_acc       <= FP_ZERO;
            r_nan       <= 1'b0;
            r_special   <= 1'b0;
            r_spec_val  <= FP_ZERO;
            r_sign      <= 1'b0;
            r_sub       <= 1'b0;
            r_exp       <= '0;
            r_big_sig   <= '0;
            r_small_sig <= '0;
            r_sum       <= '0;
            r_norm      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op   <= in_data;
                        r_last <= in_last;
                    end
                end
                S_ALIGN: begin
                    r_nan       <= r_nan | w_nan_set;
                    r_special   <= w_special;
                    r_spec_val  <= w_spec_val;
                    r_sign      <= w_big[31];
                    r_sub       <= w_big[31] ^ w_small[31];
                    r_exp       <= XW'(w_big[30:23]);
                    r_big_sig   <= w_big_sig;
                    r_small_sig <= w_small_aligned;
                end
                S_ADD: begin
                    r_sum <= r_sub ? ({1'b0, r_big_sig} - {1'b0, r_small_sig})
                                   : ({1'b0, r_big_sig} + {1'b0, r_small_sig});
                end
                S_NORM: begin
                    if (r_sum[W]) begin
                        r_norm <= r_sum[W:1] | {{(W-1){1'b0}}, r_sum[0]};
                        r_exp  <= r_exp + XW'(1);
                    end else begin
                        r_norm <= r_sum[W-1:0] << w_lz;
                        r_exp  <= r_exp - XW'(w_lz);
                    end
                end
                S_ROUND: begin
                    r_acc <= w_packed;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_acc <= FP_ZERO;
                        r_nan <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_facc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_facc : directed and randomized self-checking bench for facc             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_facc;

`ifdef FACC_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_last, out_ready;
    logic        in_ready, out_valid, busy;
    logic [31:0] in_data, out_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    facc #(
        .GUARD_BITS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact value as a wide fixed-point integer; unit = 2^-149.
    function automatic logic signed [299:0] to_fix(input logic [31:0] f);
        logic signed [299:0] v;
        int e;
        e = int'(f[30:23]);
        if (e == 0) return '0;
        v = 300'({1'b1, f[22:0]});
        v = v << (e - 1);
        return f[31] ? -v : v;
    endfunction

    // Exact sum, then truncate (or round to nearest even) to single precision.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic signed [299:0] s;
        logic [299:0]        mag, rest_mask;
        logic [24:0]         sig;
        logic                neg, g, rest;
        int                  p, e, k;
        s = to_fix(a) + to_fix(b);
        if (s == 0) return 32'h0;
        neg = s[299];
        mag = neg ? 300'(-s) : 300'(s);
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e    = p - 22;
        g    = 1'b0;
        rest = 1'b0;
        if (p >= 23) begin
            k   = p - 23;
            sig = 25'(mag >> k);
            if (k > 0) begin
                g         = mag[k-1];
                rest_mask = (300'(1) << (k - 1)) - 300'(1);
                rest      = |(mag & rest_mask);
            end
        end else begin
            sig = 25'(mag << (23 - p));
        end
        if (RNE && g && (rest || sig[0])) sig = sig + 25'd1;
        if (sig[24]) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        if (e >= 255) return {neg, 8'hFF, 23'h0};
        if (e <= 0) return 32'h0;
        return {neg, 8'(e), sig[22:0]};
    endfunction

    task automatic send(input logic [31:0] d, input logic last, output int tcyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tcyc     = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check({tag, "_timeout"}, {31'b0, out_valid}, 32'd1);
    endtask

    task automatic recv(input string tag, input logic [31:0] exp, output int vcyc);
        wait_out(tag);
        vcyc = cyc;
        check(tag, out_data, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic group2(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int t;
        send(a, 1'b0, t);
        send(b, 1'b1, t);
        recv(tag, exp, t);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int          t0, t1, tv;
        int          n;
        logic [31:0] op, m_acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data",  out_data,           32'h0);
        check("rst_busy",      {31'b0, busy},      32'd0);

        // 1.0 + 2.0 with back-to-back operands and latency check
        send(32'h3F80_0000, 1'b0, t0);
        check("busy_after_xfer", {31'b0, busy}, 32'd1);
        send(32'h4000_0000, 1'b1, t1);
        check("accept_spacing", 32'(t1 - t0), 32'd5);
        recv("one_plus_two", 32'h4040_0000, tv);
        check("out_latency", 32'(tv - t0), 32'd10);

        group2("cancel",      32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
        group2("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
        send(32'h3F80_0000, 1'b1, t0);
        recv("nan_cleared", 32'h3F80_0000, tv);
        group2("overflow",    32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
        group2("round_case",  32'h3F80_0001, 32'h3380_0000,
               RNE ? 32'h3F80_0002 : 32'h3F80_0001);
        group2("inf_plus_fin", 32'h7F80_0000, 32'hBF80_0000, 32'h7F80_0000);
        group2("nan_operand", 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
        group2("subnormal",   32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000);
        group2("neg_sum",     32'hC000_0000, 32'h3F80_0000, 32'hBF80_0000);

        // Stall in OUT, then reset while the result is pending
        send(32'h3F80_0000, 1'b1, t0);
        wait_out("stall");
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_data",  out_data,           32'h3F80_0000);
            check("stall_ready", {31'b0, in_ready},  32'd0);
            @(negedge clk);
        end
        pulse_reset();
        check("out_rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("out_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("out_rst_out_data",  out_data,           32'h0);
        check("out_rst_busy",      {31'b0, busy},      32'd0);
        send(32'h4000_0000, 1'b1, t0);
        recv("after_out_rst", 32'h4000_0000, tv);

        // Reset mid-group discards the in-flight operand and accumulator
        send(32'h4040_0000, 1'b0, t0);
        @(negedge clk);
        pulse_reset();
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        send(32'h3F80_0000, 1'b1, t0);
        recv("after_mid_rst", 32'h3F80_0000, tv);

        // Randomized groups against the exact-arithmetic model
        m_acc = 32'h0;
        for (int g = 0; g < 30; g++) begin
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) begin
                if (m_acc != 32'h0 && $urandom_range(0, 5) == 0) begin
                    op = m_acc ^ 32'h8000_0000;
                end else begin
                    op = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
                end
                send(op, (k == n - 1), t0);
                m_acc = ref_add(m_acc, op);
            end
            recv("random_group", m_acc, tv);
            m_acc = 32'h0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/facc.md
FACC -- requirements
Module: facc

Interface
REQ-001 Parameter GUARD_BITS, default 3, extra low-order alignment bits (guard, round, sticky) kept below the 24-bit significand; legal range 3..8.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  in_data/in_last valid (fed by the fmult product stage).
REQ-005 in_ready  output  1  block accepts an operand this cycle.
REQ-006 in_data  input  32  IEEE-754 single-precision operand.
REQ-007 in_last  input  1  marks the final operand of an accumulation group.
REQ-008 out_valid  output  1  out_data holds a completed group sum.
REQ-009 out_ready  input  1  downstream accepts out_data.
REQ-010 out_data  output  32  IEEE-754 single-precision accumulated sum.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL use FSM states IDLE, ALIGN, ADD, NORM, ROUND and OUT.
REQ-013 in_ready SHALL be high only in IDLE; a transfer SHALL occur when in_valid && in_ready.
REQ-014 A transfer SHALL register the operand and in_last, then walk ALIGN -> ADD -> NORM -> ROUND (one cycle each); ROUND SHALL go to OUT when the stored last flag is set, else to IDLE.
REQ-015 The next operand SHALL be accepted no sooner than 5 cycles after the previous transfer.
REQ-016 ALIGN: the smaller-exponent significand SHALL be right-shifted by the exponent difference, with shifted-out bits ORed into sticky; a difference > 24+GUARD_BITS SHALL reduce it to sticky only.
REQ-017 ADD: same signs add magnitudes; differing signs subtract smaller from larger, taking the larger's sign.
REQ-018 NORM: carry-out SHALL right-shift by 1 (exponent +1); otherwise a leading-zero count SHALL left-shift in one cycle (exponent decremented accordingly).
REQ-019 ROUND: the result SHALL be packed into the accumulator register per REQ-029.
REQ-020 Exponent >= 255 after ROUND SHALL produce signed infinity; exponent <= 0 SHALL produce 32'h00000000.
REQ-021 An operand with exponent 0 (zero or subnormal) SHALL be treated as +0.
REQ-022 An exactly cancelled sum SHALL be 32'h00000000.
REQ-023 Any NaN operand SHALL set a sticky NaN flag; inf + opposite-signed inf SHALL also set it; while set, the group result SHALL be 32'h7FC00000.
REQ-024 Infinity plus any finite value SHALL remain that infinity.
REQ-025 OUT: out_valid SHALL be high and out_data stable until out_ready; on handshake the accumulator SHALL reload to +0, the NaN flag SHALL clear, and the FSM SHALL return to IDLE.
REQ-026 out_valid and in_ready SHALL never be high together.

Reset
REQ-027 On rst (including mid-group or in OUT) the state SHALL be IDLE, the accumulator +0 and the NaN flag clear, with outputs in_ready=1, out_valid=0, out_data=0, busy=0 on the following cycle.
REQ-028 The operand in flight at reset SHALL be discarded.

Configuration
REQ-029 With FACC_ROUND_NEAREST_EN defined, ROUND SHALL apply round-to-nearest-even using guard/round/sticky, with a rounding carry renormalising the exponent; without it, ROUND SHALL truncate, matching the fmult truncation behaviour.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, FP_NAN=32'h7FC00000, FP_POS_INF=32'h7F800000, EXP_BIAS=127 and field-width constants.
REQ-031 The leading-zero counter SHALL be a sub-module named facc_lzc.

Verification
REQ-032 3F800000 then 40000000 (last) -> out_data=40400000, out_valid 10 cycles after the first transfer with no stall gaps.
REQ-033 3F800000 then BF800000 (last) -> 00000000.
REQ-034 7F800000 then FF800000 (last) -> 7FC00000; the next group 3F800000 (last) -> 3F800000 (NaN flag cleared).
REQ-035 7F7FFFFF then 7F7FFFFF (last) -> 7F800000.
REQ-036 3F800001 then 33800000 (last) -> 3F800002 with FACC_ROUND_NEAREST_EN, 3F800001 without.
REQ-037 Hold out_ready=0 for 5 cycles in OUT, then assert rst -> out_valid stays stable, in_ready stays low, then all REQ-027 values; the next group 40000000 (last) -> 40000000.
